// File: rtl/cnn_pkg.sv
// Shared types and helpers for the layer-3 pooling controller.
package cnn_pkg;

  localparam int CHANNEL_NUM = 16;
  localparam int BITS_SHIFT  = 4;
  localparam int LANE_W      = CHANNEL_NUM << BITS_SHIFT;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FEED = 3'd1,
    ST_WAIT = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } pool_ctrl_state_t;

  function automatic int win_total(input int map_w, input int map_h, input int pool_k);
    return (map_w / pool_k) * (map_h / pool_k);
  endfunction

endpackage

// File: rtl/layer3_pool_ctrl_if.sv
// Stream, array and downstream signals of the layer-3 pooling controller.
interface layer3_pool_ctrl_if
  import cnn_pkg::*;
#(
  parameter int W = LANE_W
) ();

  logic         frame_start;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [W-1:0] pool_data;
  logic         pool_start;
  logic         pool_ready;
  logic [W-1:0] pool_result;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;
  logic         frame_done;
  logic         err;

  // environment side: line buffer, pooling array, downstream and top controller
  modport master (
    output frame_start, in_valid, in_data, pool_ready, pool_result, out_ready,
    input  in_ready, pool_data, pool_start, out_valid, out_data, busy, frame_done, err
  );

  modport slave (
    input  frame_start, in_valid, in_data, pool_ready, pool_result, out_ready,
    output in_ready, pool_data, pool_start, out_valid, out_data, busy, frame_done, err
  );

endinterface

// File: rtl/layer3_pool_ctrl.sv
// Sequencer for the layer-3 16-channel max-pooling array.
// Optional WAIT watchdog compiled in with LAYER3_POOL_CTRL_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for frame_start
// FEED  | streaming pool_k*pool_k beats of one window into the array
// WAIT  | waiting for the array ready pulse
// OUT   | pooled vector held on out_data until accepted
// DONE  | frame_done pulse, then back to IDLE
module layer3_pool_ctrl
  import cnn_pkg::*;
#(
  parameter int bits        = 16,
  parameter int bits_shift  = 4,
  parameter int channel_num = 16,
  parameter int pool_k      = 2,
  parameter int map_w       = 8,
  parameter int map_h       = 8
`ifdef LAYER3_POOL_CTRL_TIMEOUT_EN
  ,
  parameter int timeout_cyc = 255
`endif
) (
  input logic               clk_in,
  input logic               rst_n,
  layer3_pool_ctrl_if.slave bus
);

  localparam int DW        = channel_num << bits_shift;
  localparam int BEATS     = pool_k * pool_k;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WIN_TOTAL = win_total(map_w, map_h, pool_k);
  localparam int WIN_W     = $clog2(WIN_TOTAL) + 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_TOTAL - 1);

`ifdef LAYER3_POOL_CTRL_TIMEOUT_EN
  localparam int              WD_W    = $clog2(timeout_cyc + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(timeout_cyc - 1);
  logic [WD_W-1:0] r_wd_cnt;
`endif

  pool_ctrl_state_t  r_state;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [WIN_W-1:0]  r_win_cnt;
  logic              r_in_ready;
  logic              r_pool_start;
  logic [DW-1:0]     r_pool_data;
  logic              r_out_valid;
  logic [DW-1:0]     r_out_data;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_err;

  logic [DW-1:0]     w_lane_mask;
  logic              w_beat_acc;

  // Lane bits above the quantization width are forced to zero on the way to the array.
  always_comb begin
    w_lane_mask = '0;
    for (int j = 0; j < DW; j++) begin
      w_lane_mask[j] = ((j % (1 << bits_shift)) < bits);
    end
  end

  assign w_beat_acc = (r_state == ST_FEED) && r_in_ready && bus.in_valid;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_beat_cnt   <= '0;
      r_win_cnt    <= '0;
      r_in_ready   <= 1'b0;
      r_pool_start <= 1'b0;
      r_pool_data  <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
`ifdef LAYER3_POOL_CTRL_TIMEOUT_EN
      r_wd_cnt     <= '0;
`endif
    end else begin
      r_pool_start <= 1'b0;
      r_frame_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.frame_start) begin
            r_beat_cnt <= '0;
            r_win_cnt  <= '0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_FEED;
          end
        end

        ST_FEED: begin
          if (w_beat_acc) begin
            r_pool_data  <= bus.in_data & w_lane_mask;
            r_pool_start <= (r_beat_cnt == '0);
            if (r_beat_cnt == BEAT_LAST) begin
              r_beat_cnt <= '0;
              r_in_ready <= 1'b0;
              r_state    <= ST_WAIT;
`ifdef LAYER3_POOL_CTRL_TIMEOUT_EN
              r_wd_cnt   <= '0;
`endif
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end else if (r_beat_cnt != '0) begin
            // upstream gapped inside a window: the array holds a partial window, abandon the frame
            r_err      <= 1'b1;
            r_beat_cnt <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end

        ST_WAIT: begin
          if (bus.pool_ready) begin
            r_out_data  <= bus.pool_result;
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end
`ifdef LAYER3_POOL_CTRL_TIMEOUT_EN
          else if (r_wd_cnt == WD_LAST) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
`endif
        end

        ST_OUT: begin
          if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_win_cnt   <= r_win_cnt + 1'b1;
            if (r_win_cnt == WIN_LAST) begin
              r_frame_done <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= ST_FEED;
            end
          end
        end

        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase

      // A ready pulse outside WAIT has no window to belong to; it overrides a same-cycle clear.
      if (bus.pool_ready && (r_state != ST_WAIT)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.pool_start = r_pool_start;
  assign bus.pool_data  = r_pool_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_layer3_pool_ctrl.sv
// Directed self-checking bench for layer3_pool_ctrl (8x8 map, 2x2 windows, 16 lanes).
module tb_layer3_pool_ctrl;
  import cnn_pkg::*;

  localparam int W = LANE_W;

  logic clk_in;
  logic rst_n;
  int   vectors;
  int   miscompares;

  layer3_pool_ctrl_if #(.W(W)) bus ();

  layer3_pool_ctrl #(
    .bits        (16),
    .bits_shift  (4),
    .channel_num (16),
    .pool_k      (2),
    .map_w       (8),
    .map_h       (8)
`ifdef LAYER3_POOL_CTRL_TIMEOUT_EN
    ,
    .timeout_cyc (20)
`endif
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [W-1:0] beat_data(input int w, input int b);
    logic [W-1:0] d;
    for (int i = 0; i < 16; i++) d[i*16 +: 16] = 16'(w * 64 + b * 16 + i + 1);
    return d;
  endfunction

  function automatic logic [W-1:0] result_data(input int w);
    logic [W-1:0] d;
    for (int i = 0; i < 16; i++) d[i*16 +: 16] = 16'(32'hC000 + w * 16 + i);
    return d;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_in_ready"},   bus.in_ready,   1'b0);
    chk1({tag, "_pool_start"}, bus.pool_start, 1'b0);
    chkw({tag, "_pool_data"},  bus.pool_data,  '0);
    chk1({tag, "_out_valid"},  bus.out_valid,  1'b0);
    chkw({tag, "_out_data"},   bus.out_data,   '0);
    chk1({tag, "_busy"},       bus.busy,       1'b0);
    chk1({tag, "_frame_done"}, bus.frame_done, 1'b0);
    chk1({tag, "_err"},        bus.err,        1'b0);
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    chk1("start_busy",     bus.busy,     1'b1);
    chk1("start_in_ready", bus.in_ready, 1'b1);
    chk1("start_err",      bus.err,      1'b0);
  endtask

  // Four back-to-back beats; each must land on pool_data the cycle after acceptance.
  task automatic feed_beats(input int w);
    chk1("feed_in_ready", bus.in_ready, 1'b1);
    for (int b = 0; b < 4; b++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = beat_data(w, b);
      step();
      chkw("pool_data",  bus.pool_data,  beat_data(w, b));
      chk1("pool_start", bus.pool_start, (b == 0));
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    chk1("wait_in_ready", bus.in_ready, 1'b0);
  endtask

  // One window with array latency 3; bp cycles of out_ready=0 before acceptance.
  task automatic run_window(input int w, input int bp);
    logic [W-1:0] res;
    res = result_data(w);
    feed_beats(w);
    step();
    step();
    if (bp > 0) bus.out_ready = 1'b0;
    bus.pool_ready  = 1'b1;
    bus.pool_result = res;
    step();
    bus.pool_ready  = 1'b0;
    bus.pool_result = '0;
    chk1("out_valid", bus.out_valid, 1'b1);
    chkw("out_lane15", W'(bus.out_data[W-1 -: 16]), W'(res[W-1 -: 16]));
    chkw("out_data", bus.out_data, res);
    for (int c = 0; c < bp; c++) begin
      step();
      chkw("bp_out_data", bus.out_data, res);
      chk1("bp_in_ready", bus.in_ready, 1'b0);
      chk1("bp_out_valid", bus.out_valid, 1'b1);
    end
    bus.out_ready = 1'b1;
    step();
    chk1("hs_out_valid", bus.out_valid, 1'b0);
    if (w == 15) begin
      chk1("done_pulse", bus.frame_done, 1'b1);
      chk1("done_busy",  bus.busy,       1'b1);
      step();
      chk1("done_clear", bus.frame_done, 1'b0);
      chk1("done_idle",  bus.busy,       1'b0);
      chk1("done_err",   bus.err,        1'b0);
    end else begin
      chk1("next_in_ready",   bus.in_ready,   1'b1);
      chk1("next_frame_done", bus.frame_done, 1'b0);
    end
  endtask

  task automatic run_windows(input int first, input int last, input int bp_win);
    for (int w = first; w <= last; w++) run_window(w, (w == bp_win) ? 10 : 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n           = 1'b0;
    bus.frame_start = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.pool_ready  = 1'b0;
    bus.pool_result = '0;
    bus.out_ready   = 1'b1;

    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk_all_zero("post_reset");

    // nominal frame
    start_frame();
    run_windows(0, 15, -1);

    // backpressure in window 3
    start_frame();
    run_windows(0, 15, 3);

    // mid-window gap after beat 1
    start_frame();
    for (int b = 0; b < 2; b++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = beat_data(0, b);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    chk1("gap_err",        bus.err,        1'b1);
    chk1("gap_busy",       bus.busy,       1'b0);
    chk1("gap_in_ready",   bus.in_ready,   1'b0);
    chk1("gap_frame_done", bus.frame_done, 1'b0);
    step();
    chk1("gap_idle_busy",  bus.busy,       1'b0);
    chk1("gap_idle_done",  bus.frame_done, 1'b0);

    // fresh start clears err; stray frame_start in FEED must not disturb the counts
    start_frame();
    run_windows(0, 4, -1);
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    chk1("stray_fs_busy",     bus.busy,     1'b1);
    chk1("stray_fs_in_ready", bus.in_ready, 1'b1);
    chk1("stray_fs_err",      bus.err,      1'b0);
    run_windows(5, 15, -1);

    // stray pool_ready in IDLE
    bus.pool_ready = 1'b1;
    step();
    bus.pool_ready = 1'b0;
    chk1("stray_pr_err",  bus.err,  1'b1);
    chk1("stray_pr_busy", bus.busy, 1'b0);

    // reset during window 7 WAIT
    start_frame();
    run_windows(0, 6, -1);
    feed_beats(7);
    step();
    chk1("pre_rst_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    step();
    rst_n = 1'b1;
    step();
    start_frame();
    run_windows(0, 15, -1);

    // array never answers
    start_frame();
    feed_beats(0);
`ifdef LAYER3_POOL_CTRL_TIMEOUT_EN
    for (int c = 0; c < 19; c++) step();
    chk1("wd_pre_err",  bus.err,  1'b0);
    chk1("wd_pre_busy", bus.busy, 1'b1);
    step();
    chk1("wd_err",  bus.err,  1'b1);
    chk1("wd_busy", bus.busy, 1'b0);
`else
    for (int c = 0; c < 40; c++) step();
    chk1("nowd_busy",      bus.busy,      1'b1);
    chk1("nowd_err",       bus.err,       1'b0);
    chk1("nowd_out_valid", bus.out_valid, 1'b0);
    chk1("nowd_in_ready",  bus.in_ready,  1'b0);
`endif

    rst_n = 1'b0;
    step();
    chk_all_zero("final_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
